// File: rtl/print_job_sched_pkg.sv
// Shared types and default parameters for the print job scheduler.
package print_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_PAGE_W       = 8;
  localparam int DEF_IDLE_TIMEOUT = 100;
  localparam int DEF_TO_W         = 7;
endpackage

// File: rtl/print_job_sched_if.sv
// Requester-side job handshake: valid/pages in, ready strobe and completion pulse out.
interface print_job_sched_if #(
  parameter int NREQ   = 4,
  parameter int PAGE_W = 8
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][PAGE_W-1:0] req_pages;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0]             job_done;

  modport master (output req_valid, req_pages, input  req_ready, job_done);
  modport slave  (input  req_valid, req_pages, output req_ready, job_done);
endinterface

// File: rtl/print_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);
  int idx;

  // Scan farthest-first so the nearest valid requester after 'last' overwrites.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    any     = |req;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/print_job_sched.sv
// Print job scheduler: round-robin job intake, one-at-a-time engine sequencing, idle sleep.
module print_job_sched
  import print_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int PAGE_W       = DEF_PAGE_W,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int TO_W         = DEF_TO_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  print_job_sched_if.slave         rq,
  input  logic                     eng_ready,
  input  logic                     eng_page_done,
  output logic                     eng_start,
  output logic [PAGE_W-1:0]        eng_pages,
  output logic                     eng_sleep,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     err_spurious
);
  localparam int IW = $clog2(NREQ);
  localparam logic [TO_W-1:0] TO_VAL = TO_W'(IDLE_TIMEOUT);

  state_t            state;
  logic [PAGE_W-1:0] remaining;
  logic [TO_W-1:0]   idle_cnt;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     gnt_idx;
  logic              any_req;
  logic              accept;
  logic [PAGE_W-1:0] win_pages;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (rq.req_valid),
    .last    (owner),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign accept       = (state == IDLE) && any_req;
  assign win_pages    = rq.req_pages[gnt_idx];
  assign rq.req_ready = accept ? gnt : '0;
  assign rq.job_done  = (state == DONE) ? (NREQ'(1) << owner) : '0;
  assign eng_start    = (state == LAUNCH) && eng_ready;
  assign busy         = (state != IDLE);
  // Sleep drops in the accept cycle itself, before the counter clears.
  assign eng_sleep    = (state == IDLE) && (idle_cnt == TO_VAL) && !any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      eng_pages    <= '0;
      remaining    <= '0;
      owner        <= IW'(NREQ - 1);
      idle_cnt     <= TO_VAL;
      err_spurious <= 1'b0;
    end else begin
      if (eng_page_done && state != RUN) err_spurious <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= gnt_idx;
            eng_pages <= win_pages;
            remaining <= win_pages;
            idle_cnt  <= '0;
            state     <= (win_pages != '0) ? LAUNCH : DONE;
          end else if (idle_cnt != TO_VAL) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        LAUNCH: if (eng_ready) state <= RUN;
        RUN: begin
          if (eng_page_done) begin
            remaining <= remaining - 1'b1;
            if (remaining == PAGE_W'(1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_print_job_sched.sv
// Bench for print_job_sched: vector table, hand sequences, randomized run against a job-level model.
module tb_print_job_sched;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          eng_ready = 1'b0;
  logic          eng_page_done = 1'b0;
  logic          eng_start, eng_sleep, busy, err_spurious;
  logic [PW-1:0] eng_pages;
  logic [1:0]    owner;

  int total = 0;
  int bad   = 0;

  print_job_sched_if #(.NREQ(N), .PAGE_W(PW)) rq();

  print_job_sched #(.NREQ(N), .PAGE_W(PW), .IDLE_TIMEOUT(TO), .TO_W(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rq            (rq.slave),
    .eng_ready     (eng_ready),
    .eng_page_done (eng_page_done),
    .eng_start     (eng_start),
    .eng_pages     (eng_pages),
    .eng_sleep     (eng_sleep),
    .busy          (busy),
    .owner         (owner),
    .err_spurious  (err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] v;  logic [7:0] p0; logic [7:0] p2; logic er; logic pd;
    logic [3:0] xr; logic xs; logic [3:0] xd; logic xb; logic [7:0] xp;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [7:0] p0, logic [7:0] p2, logic er, logic pd,
                              logic [3:0] xr, logic xs, logic [3:0] xd, logic xb, logic [7:0] xp);
    vec_t r;
    r.v = v; r.p0 = p0; r.p2 = p2; r.er = er; r.pd = pd;
    r.xr = xr; r.xs = xs; r.xd = xd; r.xb = xb; r.xp = xp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq.req_valid = '0; rq.req_pages = '0;
    eng_ready = 1'b0; eng_page_done = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  vec_t vec[15];

  initial begin
    int w, starts, first, dones;
    int m_job, m_wait, m_left, m_owner, m_idle, m_err;
    logic [7:0] m_pages;
    logic [3:0] x_ready, x_done;

    rq.req_valid = '0; rq.req_pages = '0;

    // Single 3-page job, zero-page job on requester 2, then a stalled 1-page job.
    vec[0]  = mk(4'b0001, 8'd3, 8'd0, 1, 0, 4'b0001, 0, 4'b0000, 0, 8'd0);
    vec[1]  = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 1, 4'b0000, 1, 8'd3);
    vec[2]  = mk(4'b0000, 8'd0, 8'd0, 1, 1, 4'b0000, 0, 4'b0000, 1, 8'd3);
    vec[3]  = mk(4'b0000, 8'd0, 8'd0, 1, 1, 4'b0000, 0, 4'b0000, 1, 8'd3);
    vec[4]  = mk(4'b0000, 8'd0, 8'd0, 1, 1, 4'b0000, 0, 4'b0000, 1, 8'd3);
    vec[5]  = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 0, 4'b0001, 1, 8'd3);
    vec[6]  = mk(4'b0100, 8'd0, 8'd0, 1, 0, 4'b0100, 0, 4'b0000, 0, 8'd3);
    vec[7]  = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 0, 4'b0100, 1, 8'd0);
    vec[8]  = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 0, 4'b0000, 0, 8'd0);
    vec[9]  = mk(4'b0100, 8'd0, 8'd1, 0, 0, 4'b0100, 0, 4'b0000, 0, 8'd0);
    vec[10] = mk(4'b0000, 8'd0, 8'd0, 0, 0, 4'b0000, 0, 4'b0000, 1, 8'd1);
    vec[11] = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 1, 4'b0000, 1, 8'd1);
    vec[12] = mk(4'b0000, 8'd0, 8'd0, 1, 1, 4'b0000, 0, 4'b0000, 1, 8'd1);
    vec[13] = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 0, 4'b0100, 1, 8'd1);
    vec[14] = mk(4'b0000, 8'd0, 8'd0, 1, 0, 4'b0000, 0, 4'b0000, 0, 8'd1);

    // Reset values
    do_reset();
    #2;
    chk("rst_ready", rq.req_ready, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, N - 1);
    chk("rst_done", rq.job_done, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_sleep", eng_sleep, 1);
    chk("rst_pages", eng_pages, 0);
    tick();

    // Vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      rq.req_valid = vec[i].v;
      rq.req_pages = '0;
      rq.req_pages[0] = vec[i].p0;
      rq.req_pages[2] = vec[i].p2;
      eng_ready = vec[i].er;
      eng_page_done = vec[i].pd;
      #2;
      chk($sformatf("vec%0d_ready", i), rq.req_ready, vec[i].xr);
      chk($sformatf("vec%0d_start", i), eng_start, vec[i].xs);
      chk($sformatf("vec%0d_done", i), rq.job_done, vec[i].xd);
      chk($sformatf("vec%0d_busy", i), busy, vec[i].xb);
      chk($sformatf("vec%0d_pages", i), eng_pages, vec[i].xp);
      tick();
    end

    // Fairness: everyone valid with 1-page jobs
    do_reset();
    rq.req_valid = '1;
    for (int i = 0; i < N; i++) rq.req_pages[i] = 8'd1;
    eng_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      w = -1;
      for (int c = 0; c < 8 && w < 0; c++) begin
        #2;
        for (int i = 0; i < N; i++) if (rq.req_ready[i]) w = i;
        if (w < 0) tick();
      end
      chk($sformatf("rr_order%0d", g), w, g % N);
      tick();                       // LAUNCH
      tick(); eng_page_done = 1'b1; // RUN
      tick(); eng_page_done = 1'b0; // DONE
      tick();
    end

    // Engine stall in LAUNCH, then idle sleep after the job
    do_reset();
    rq.req_valid = 4'b0010;
    rq.req_pages[1] = 8'd2;
    #2;
    chk("stall_acc", rq.req_ready, 4'b0010);
    tick();
    rq.req_valid = '0;
    starts = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (eng_start) starts++;
      if (!busy) starts += 100;
      tick();
    end
    chk("stall_hold", starts, 0);
    eng_ready = 1'b1;
    #2;
    chk("stall_start", eng_start, 1);
    tick(); #2;
    chk("stall_once", eng_start, 0);
    eng_page_done = 1'b1;
    tick();
    tick(); eng_page_done = 1'b0;
    #2;
    chk("stall_done", rq.job_done, 4'b0010);
    first = -1;
    for (int k = 1; k <= 130; k++) begin
      tick(); #2;
      if (eng_sleep && first < 0) first = k;
    end
    chk("sleep_delay", first, TO + 1);
    rq.req_valid = 4'b0001;
    rq.req_pages[0] = 8'd0;
    #1;
    chk("sleep_drop", eng_sleep, 0);
    chk("sleep_acc", rq.req_ready, 4'b0001);
    tick();

    // Spurious page_done, then reset in the middle of a job
    do_reset();
    eng_page_done = 1'b1;
    tick();
    eng_page_done = 1'b0;
    #2;
    chk("spur_err", err_spurious, 1);
    rq.req_valid = 4'b0001;
    rq.req_pages[0] = 8'd3;
    eng_ready = 1'b1;
    #1;
    chk("spur_acc", rq.req_ready, 4'b0001);
    tick(); rq.req_valid = '0;
    tick();
    eng_page_done = 1'b1;
    tick();
    eng_page_done = 1'b0;
    #2;
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_pages", eng_pages, 0);
    chk("mid_owner", owner, N - 1);
    chk("mid_err", err_spurious, 0);
    chk("mid_sleep", eng_sleep, 1);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 1) rst_n = 1'b1;
      #2;
      if (rq.job_done != 0) dones++;
    end
    chk("mid_no_done", dones, 0);

    // Randomized run against a job-level model
    do_reset();
    m_job = 0; m_wait = 0; m_left = 0; m_owner = N - 1; m_idle = TO; m_err = 0; m_pages = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rq.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) rq.req_pages[i] = 8'($urandom_range(0, 3));
      eng_ready = ($urandom_range(0, 3) != 0);
      eng_page_done = ($urandom_range(0, 1) == 0);
      #2;
      w = -1;
      if (m_job == 0)
        for (int k = N; k >= 1; k--)
          if (rq.req_valid[(m_owner + k) % N]) w = (m_owner + k) % N;
      x_ready = (w >= 0) ? 4'(1 << w) : 4'b0;
      x_done  = (m_job != 0 && m_wait == 0 && m_left == 0) ? 4'(1 << m_owner) : 4'b0;
      chk("rnd_ready", rq.req_ready, x_ready);
      chk("rnd_done", rq.job_done, x_done);
      chk("rnd_start", eng_start, (m_job != 0 && m_wait != 0 && eng_ready));
      chk("rnd_busy", busy, (m_job != 0));
      chk("rnd_sleep", eng_sleep, (m_job == 0 && m_idle >= TO && rq.req_valid == 0));
      chk("rnd_pages", eng_pages, m_pages);
      chk("rnd_owner", owner, m_owner);
      chk("rnd_err", err_spurious, m_err);
      if (eng_page_done && !(m_job != 0 && m_wait == 0 && m_left > 0)) m_err = 1;
      if (m_job == 0) begin
        if (w >= 0) begin
          m_job = 1; m_owner = w; m_pages = rq.req_pages[w];
          m_left = m_pages; m_wait = (m_left != 0); m_idle = 0;
        end else if (m_idle < TO) m_idle++;
      end else if (m_wait != 0) begin
        if (eng_ready) m_wait = 0;
      end else if (m_left == 0) begin
        m_job = 0;
      end else if (eng_page_done) begin
        m_left--;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/print_job_sched.md
# print_job_sched

Print job scheduler sitting between several job sources (host ports, copy path, fax path) and the single print engine. It accepts page-count jobs through valid/ready handshakes and arbitrates between requesters round-robin. It sequences the engine one job at a time with a start pulse, counts per-page completions, and reports job completion to the owning requester. An idle timer asks the engine to drop back to its sleep state after a configurable quiet period.

## Interface
- NREQ, 4: number of requesters (2..8)
- PAGE_W, 8: width of page count
- IDLE_TIMEOUT, 100: idle cycles before eng_sleep asserts (1..2^TO_W-1)
- TO_W, 7: idle counter width
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester job request
- req_pages  in  NREQ*PAGE_W  packed page counts, requester i at bits [i*PAGE_W +: PAGE_W]
- req_ready  out  NREQ  one-hot accept strobe
- eng_ready  in  1  engine idle and able to take a job
- eng_page_done  in  1  one-cycle pulse per printed page
- eng_start  out  1  one-cycle job launch pulse
- eng_pages  out  PAGE_W  page count of current job, held stable while busy
- eng_sleep  out  1  level: engine may sleep
- busy  out  1  job in flight (LAUNCH, RUN or DONE)
- owner  out  $clog2(NREQ)  index of current/last granted requester
- job_done  out  NREQ  one-cycle completion pulse to owner
- err_spurious  out  1  sticky: eng_page_done seen outside RUN

## Operation
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE: if any req_valid, winner = first valid requester scanning from (owner+1) mod NREQ upward with wrap; req_ready[winner]=1 combinationally that cycle; handshake completes; latch pages into eng_pages and remaining, owner <= winner.
  - pages != 0 -> LAUNCH. pages == 0 -> DONE directly (no eng_start).
- LAUNCH: wait for eng_ready=1; on that cycle eng_start=1 -> RUN.
- RUN: each eng_page_done decrements remaining; if it arrives when remaining==1 -> DONE.
- DONE: job_done[owner]=1 for exactly one cycle -> IDLE.
- req_ready is zero in every state except IDLE; at most one bit set.
- Idle counter: counts up in IDLE, saturates at IDLE_TIMEOUT; eng_sleep = (counter == IDLE_TIMEOUT) && state==IDLE. Counter clears to 0 on any accepted job.
- eng_page_done outside RUN: ignored for counting, sets err_spurious (cleared only by reset).
- Requester deasserting req_valid before grant is legal; no job is recorded.

## Timing
- Reset values: state IDLE, req_ready 0, eng_start 0, eng_pages 0, busy 0, owner NREQ-1 (so requester 0 wins first), job_done 0, err_spurious 0, idle counter = IDLE_TIMEOUT (eng_sleep=1 out of reset).
- Accept to eng_start: minimum 1 cycle (accept cycle N, eng_start cycle N+1 if eng_ready high).
- Last eng_page_done at cycle M -> job_done at M+1 -> next accept possible at M+2.
- Zero-page job: accept at N, job_done at N+1.
- busy high from cycle after accept through DONE cycle inclusive.
- eng_sleep drops combinationally in the accept cycle; next assert after IDLE_TIMEOUT idle cycles.
- Reset mid-job: all state discarded immediately, no job_done issued; engine side must be reset together.

## Structure
- Package print_pkg: state enum (IDLE, LAUNCH, RUN, DONE) as 2-bit localparams, default PAGE_W and IDLE_TIMEOUT.
- Sub-module rr_arbiter (NREQ, combinational grant from request vector and last-owner pointer) instantiated once; counters and FSM in the top.

## Test plan
- Single job: req_valid[0], pages=3, eng_ready=1 -> req_ready[0] same cycle, eng_start next cycle, eng_pages=3, job_done[0] one cycle after 3rd page_done.
- Fairness: all four requesters valid continuously, pages=1 -> grant order 0,1,2,3,0.
- Zero pages: requester 2, pages=0 -> job_done[2] one cycle after accept, eng_start never asserted.
- Engine stall: eng_ready=0 for 10 cycles after accept -> FSM holds LAUNCH, eng_start pulses once when eng_ready rises.
- Idle sleep: IDLE_TIMEOUT=100, no requests after a job -> eng_sleep asserts exactly 100 cycles after return to IDLE, deasserts in next accept cycle.
- Spurious/reset: page_done in IDLE -> err_spurious=1, counts unaffected; rst_n low during RUN -> all outputs to reset values, no job_done.
